// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle: instruction-memory request/response, IF/ID output
// handshake and EX redirect, seen from the prefetch queue as master.
interface if_prefetch_queue_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc_plus;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_instr, out_pc_plus,
    input  out_ready,
    input  redirect, redirect_pc,
    output halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_instr, out_pc_plus,
    output out_ready,
    output redirect, redirect_pc,
    input  halted
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Prefetching IF front end: credit-limited sequential fetch, in-order queue,
// redirect flush with stale-response drop. Optional IFQ_BYPASS_EN bypass.
module if_prefetch_queue #(
  parameter int               ADDR_W   = 16,
  parameter int               INSTR_W  = 16,
  parameter int               DEPTH    = 4,
  parameter int               PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HLT_OPC  = 4'hF
) (
  input logic clk,
  input logic rst,
  if_prefetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = CW + 4;

  typedef enum logic {RUN, HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [PW-1:0]     tw_q, tw_d;
  logic [PW-1:0]     tr_q, tr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [DW-1:0]     drop_q, drop_d;

  logic [INSTR_W-1:0] qi_q [DEPTH];
  logic [ADDR_W-1:0]  qp_q [DEPTH];
  logic [ADDR_W-1:0]  tag_q [DEPTH];

  logic              issue, acc, enq, qdeq;
  logic              head_v, byp, hlt;
  logic [CW:0]       credit;
  logic [ADDR_W-1:0] pc_nxt;

  assign pc_nxt = pc_q + ADDR_W'(PC_INC);
  assign credit = {1'b0, cnt_q} + {1'b0, outst_q};
  assign head_v = (cnt_q != '0);

  assign bus.imem_req  = ~rst & (state_q == RUN) & ~bus.redirect
                       & (credit < (CW+1)'(DEPTH));
  assign bus.imem_addr = pc_q;
  assign bus.halted    = (state_q == HALT);

  assign issue = bus.imem_req & bus.imem_gnt;
  assign acc   = bus.imem_rvalid & ~bus.redirect & (drop_q == '0);
  assign hlt   = acc & (bus.imem_rdata[INSTR_W-1 -: 4] == HLT_OPC);

`ifdef IFQ_BYPASS_EN
  assign byp = acc & ~head_v;
`else
  assign byp = 1'b0;
`endif

  // A bypassed response that is taken immediately never touches the queue
  assign qdeq = head_v & bus.out_valid & bus.out_ready;
  assign enq  = acc & ~(byp & bus.out_ready);

  always_comb begin
    bus.out_valid   = (head_v | byp) & ~bus.redirect;
    bus.out_instr   = '0;
    bus.out_pc_plus = '0;
    if (head_v) begin
      bus.out_instr   = qi_q[rp_q];
      bus.out_pc_plus = qp_q[rp_q];
    end else if (byp) begin
      bus.out_instr   = bus.imem_rdata;
      bus.out_pc_plus = tag_q[tr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    tw_d    = tw_q;
    tr_d    = tr_q;
    cnt_d   = cnt_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    if (bus.redirect) begin
      state_d = RUN;
      pc_d    = bus.redirect_pc;
      wp_d    = '0;
      rp_d    = '0;
      tw_d    = '0;
      tr_d    = '0;
      cnt_d   = '0;
      outst_d = '0;
      // Everything still owed by memory is stale, minus what lands now
      drop_d  = DW'(outst_q) + drop_q - DW'(bus.imem_rvalid);
    end else begin
      if (issue) begin
        pc_d = pc_nxt;
        tw_d = tw_q + PW'(1);
      end
      if (bus.imem_rvalid && drop_q != '0) drop_d = drop_q - DW'(1);
      if (acc) tr_d = tr_q + PW'(1);
      if (enq) wp_d = wp_q + PW'(1);
      if (qdeq) rp_d = rp_q + PW'(1);
      outst_d = outst_q + CW'(issue) - CW'(acc);
      cnt_d   = cnt_q + CW'(enq) - CW'(qdeq);
      if (hlt) state_d = HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      wp_q    <= '0;
      rp_q    <= '0;
      tw_q    <= '0;
      tr_q    <= '0;
      cnt_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      tw_q    <= tw_d;
      tr_q    <= tr_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_q[tw_q] <= pc_nxt;
    if (enq) begin
      qi_q[wp_q] <= bus.imem_rdata;
      qp_q[wp_q] <= tag_q[tr_q];
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: memory model with in-order
// responses, expected entries queued at response time and popped on dequeue.
module tb_if_prefetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_prefetch_queue_if #(.ADDR_W(16), .INSTR_W(16)) b ();

  if_prefetch_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (b.master)
  );

  typedef struct {
    logic [15:0] addr;
    bit          stale;
  } fl_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pcp;
  } ent_t;

  fl_t         infl[$];
  ent_t        sb[$];
  logic [15:0] issued[$];
  logic [15:0] deq_log[$];

  int          checks = 0;
  int          errors = 0;
  int          nissue = 0;
  int          n0;
  bit          mem_en = 1'b1;
  bit          hlt_on = 1'b0;
  bit          halt_m = 1'b0;
  bit          halt_n = 1'b0;
  logic [15:0] pc_m = 16'h0000;
  logic [15:0] hlt_pcp = 16'hFFFF;
  logic        last_valid;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem(logic [15:0] a);
    if (hlt_on && a == 16'h0006) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  function automatic logic [15:0] qat(logic [15:0] q[$], int i);
    if (q.size() > i) return q[i];
    return 16'hxxxx;
  endfunction

  task automatic tick();
    fl_t  f;
    ent_t e;
    bit   acc;
    bit   exp_req;
    bit   exp_v;
    int   live;
    if (mem_en && infl.size() > 0) begin
      b.imem_rvalid = 1'b1;
      b.imem_rdata  = mem(infl[0].addr);
    end else begin
      b.imem_rvalid = 1'b0;
      b.imem_rdata  = 16'h0000;
    end
    @(negedge clk);
    live = 0;
    foreach (infl[i]) if (!infl[i].stale) live++;
    exp_req = !halt_m && !b.redirect && (sb.size() + live < 4);
    acc = 1'b0;
    e.ins = 16'h0;
    e.pcp = 16'h0;
    if (b.imem_rvalid) begin
      f = infl.pop_front();
      acc = !f.stale && !b.redirect;
      e.ins = b.imem_rdata;
      e.pcp = f.addr + 16'd2;
    end
`ifdef IFQ_BYPASS_EN
    if (acc) sb.push_back(e);
`endif
    exp_v = (sb.size() > 0) && !b.redirect;
    last_valid = b.out_valid;
    chk("req", b.imem_req, exp_req);
    chk("valid", b.out_valid, exp_v);
    chk("halted", b.halted, halt_m);
    if (exp_v && b.out_ready) begin
      chk("instr", b.out_instr, sb[0].ins);
      chk("pc_plus", b.out_pc_plus, sb[0].pcp);
      deq_log.push_back(b.out_pc_plus);
      if (sb[0].ins == 16'hF000) hlt_pcp = b.out_pc_plus;
      void'(sb.pop_front());
    end
    if (b.imem_req && b.imem_gnt) begin
      chk("addr", b.imem_addr, pc_m);
      issued.push_back(pc_m);
      f.addr  = pc_m;
      f.stale = 1'b0;
      infl.push_back(f);
      pc_m = pc_m + 16'd2;
      nissue++;
    end
`ifndef IFQ_BYPASS_EN
    if (acc) sb.push_back(e);
`endif
    if (acc && e.ins[15:12] == 4'hF) halt_n = 1'b1;
    if (b.redirect) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      sb.delete();
      pc_m   = b.redirect_pc;
      halt_n = 1'b0;
    end
    @(posedge clk);
    #1;
    halt_m = halt_n;
  endtask

  task automatic do_redirect(logic [15:0] pc);
    b.redirect    = 1'b1;
    b.redirect_pc = pc;
    tick();
    b.redirect    = 1'b0;
  endtask

  initial begin
    b.imem_gnt    = 1'b1;
    b.imem_rvalid = 1'b0;
    b.imem_rdata  = 16'h0;
    b.out_ready   = 1'b1;
    b.redirect    = 1'b0;
    b.redirect_pc = 16'h0;

    // Reset state
    @(negedge clk);
    chk("rst_req", b.imem_req, 1'b0);
    chk("rst_valid", b.out_valid, 1'b0);
    chk("rst_halted", b.halted, 1'b0);
    chk("rst_instr", b.out_instr, 16'h0);
    chk("rst_pcp", b.out_pc_plus, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: streaming sequential fetch
    repeat (12) tick();
    chk("t1_a0", qat(issued, 0), 16'h0000);
    chk("t1_a2", qat(issued, 2), 16'h0004);
    chk("t1_p0", qat(deq_log, 0), 16'h0002);

    // 2: stalled consumer fills exactly DEPTH credits
    b.imem_gnt = 1'b0;
    repeat (4) tick();
    b.imem_gnt  = 1'b1;
    b.out_ready = 1'b0;
    n0 = nissue;
    repeat (10) tick();
    chk("t2_issues", nissue - n0, 4);
    chk("t2_req", b.imem_req, 1'b0);
    b.out_ready = 1'b1;
    repeat (10) tick();

    // 3: redirect with three requests outstanding
    b.imem_gnt = 1'b0;
    repeat (4) tick();
    mem_en = 1'b0;
    b.imem_gnt = 1'b1;
    repeat (3) tick();
    do_redirect(16'h0100);
    mem_en = 1'b1;
    issued.delete();
    deq_log.delete();
    repeat (10) tick();
    chk("t3_addr", qat(issued, 0), 16'h0100);
    chk("t3_pcp", qat(deq_log, 0), 16'h0102);

    // 4: redirect colliding with a response and a ready consumer
    do_redirect(16'h0200);
    chk("t4_valid", last_valid, 1'b0);
    repeat (6) tick();

    // 5: HLT stops fetching; redirect restarts
    hlt_on = 1'b1;
    do_redirect(16'h0000);
    repeat (12) tick();
    chk("t5_halted", b.halted, 1'b1);
    chk("t5_hlt_pcp", hlt_pcp, 16'h0008);
    n0 = nissue;
    repeat (5) tick();
    chk("t5_noissue", nissue - n0, 0);
    hlt_on = 1'b0;
    do_redirect(16'h0000);
    issued.delete();
    tick();
    chk("t5_resume", b.halted, 1'b0);
    repeat (4) tick();
    chk("t5_addr", qat(issued, 0), 16'h0000);

    // 6: fetch PC wraps past the top of the address space
    do_redirect(16'hFFFC);
    issued.delete();
    repeat (8) tick();
    chk("t6_a0", qat(issued, 0), 16'hFFFC);
    chk("t6_a1", qat(issued, 1), 16'hFFFE);
    chk("t6_a2", qat(issued, 2), 16'h0000);

    b.imem_gnt = 1'b0;
    repeat (6) tick();
    chk("end_empty", b.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
